// File: rtl/ram_arb_pkg.sv
// Shared types for the cpu/host ram arbiter.
// Ownership states and ram port widths.
package ram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CPU_OWN,
    DRAIN,
    HOST_OWN,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid shift pipe tracking host reads in flight through the ram.
// done marks the cycle ram_q holds the oldest launched read.
module ram_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic launch,
  output logic done,
  output logic busy
);

  logic [RD_LAT-1:0] vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= launch;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign done = vld[RD_LAT-1];
  assign busy = |vld;

endmodule

// File: rtl/ram_host_arbiter.sv
// Shares the single-port ram between the cpu and a host loader.
// Host gets the ram only once the cpu sits in its await stage.
module ram_host_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int DRAIN_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rden,
  input  logic              cpu_wren,
  input  logic              cpu_await,
  output logic              cpu_halt,
  output logic              cpu_run,
  input  logic              h_req,
  output logic              h_gnt,
  input  logic              h_valid,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  output logic              drain_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic [CW-1:0] drain_cnt;
  logic          was_running;
  logic          cpu_fwd;
  logic          launch;
  logic          rd_done;
  logic          rd_busy;

  ram_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .launch(launch),
    .done  (rd_done),
    .busy  (rd_busy)
  );

  assign h_gnt    = (state == HOST_OWN);
  assign cpu_halt = (state != CPU_OWN);
  assign cpu_fwd  = (state == CPU_OWN) || (state == DRAIN);
  assign launch   = h_gnt & h_valid & ~h_we;

  always_comb begin
    state_nx = state;
    unique case (state)
      CPU_OWN: begin
        if (h_req) state_nx = cpu_await ? HOST_OWN : DRAIN;
      end
      DRAIN: begin
        if (!h_req)         state_nx = RELEASE;
        else if (cpu_await) state_nx = HOST_OWN;
      end
      HOST_OWN: begin
        if (!h_req) state_nx = RELEASE;
      end
      RELEASE: begin
        if (!rd_busy) state_nx = CPU_OWN;
      end
      default: state_nx = CPU_OWN;
    endcase
  end

  // RELEASE parks the port: cpu address, no strobes
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    unique case (1'b1)
      h_gnt: begin
        ram_addr  = h_addr;
        ram_wdata = h_wdata;
        ram_rden  = h_valid & ~h_we;
        ram_wren  = h_valid & h_we;
      end
      cpu_fwd: begin
        ram_rden = cpu_rden;
        ram_wren = cpu_wren;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CPU_OWN;
      drain_cnt   <= '0;
      drain_err   <= 1'b0;
      was_running <= 1'b0;
      cpu_run     <= 1'b0;
      h_rvalid    <= 1'b0;
      h_rdata     <= '0;
    end else begin
      state    <= state_nx;
      cpu_run  <= (state == RELEASE) && !rd_busy && was_running;
      h_rvalid <= rd_done;
      if (rd_done) h_rdata <= ram_q;
      if (state == CPU_OWN && h_req) was_running <= !cpu_await;
      if (state != DRAIN) begin
        drain_cnt <= '0;
      end else if (drain_cnt != CW'(DRAIN_MAX)) begin
        drain_cnt <= drain_cnt + CW'(1);
      end
      if (state == DRAIN && drain_cnt == CW'(DRAIN_MAX)) drain_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Directed bench for ram_host_arbiter with a 1-cycle-latency ram.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_ram_host_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_rden, cpu_wren, cpu_await;
  logic       cpu_halt, cpu_run;
  logic       h_req, h_gnt, h_valid, h_we;
  logic [7:0] h_addr, h_wdata, h_rdata;
  logic       h_rvalid, drain_err;
  logic [7:0] ram_addr, ram_wdata, ram_q;
  logic       ram_rden, ram_wren;
  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_host_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rden (cpu_rden),
    .cpu_wren (cpu_wren),
    .cpu_await(cpu_await),
    .cpu_halt (cpu_halt),
    .cpu_run  (cpu_run),
    .h_req    (h_req),
    .h_gnt    (h_gnt),
    .h_valid  (h_valid),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_rdata  (h_rdata),
    .h_rvalid (h_rvalid),
    .drain_err(drain_err),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rden (ram_rden),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    cpu_addr = 8'h33; cpu_wdata = 8'h00;
    cpu_rden = 1'b1; cpu_wren = 1'b0; cpu_await = 1'b1;
    h_req = 1'b0; h_valid = 1'b0; h_we = 1'b0;
    h_addr = 8'h00; h_wdata = 8'h00;
    #2;
    chk("rst_halt", 32'(cpu_halt), 0);
    chk("rst_run", 32'(cpu_run), 0);
    chk("rst_gnt", 32'(h_gnt), 0);
    chk("rst_rvalid", 32'(h_rvalid), 0);
    chk("rst_rdata", 32'(h_rdata), 0);
    chk("rst_derr", 32'(drain_err), 0);
    chk("rst_mux_addr", 32'(ram_addr), 32'h33);
    chk("rst_mux_rden", 32'(ram_rden), 1);
    h_valid = 1'b1;
    cpu_rden = 1'b0;
    #1;
    chk("hvalid_nogrant", 32'(ram_rden), 0);
    h_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();

    // 1: takeover from await, write then read back
    h_req = 1'b1;
    tick();
    chk("t1_gnt", 32'(h_gnt), 1);
    chk("t1_halt", 32'(cpu_halt), 1);
    h_valid = 1'b1; h_we = 1'b1; h_addr = 8'h10; h_wdata = 8'h5A;
    #1;
    chk("t1_wren", 32'(ram_wren), 1);
    chk("t1_waddr", 32'(ram_addr), 32'h10);
    chk("t1_wdata", 32'(ram_wdata), 32'h5A);
    tick();
    h_we = 1'b0;
    #1;
    chk("t1_rden", 32'(ram_rden), 1);
    tick();
    h_valid = 1'b0;
    chk("t1_rvalid_early", 32'(h_rvalid), 0);
    tick();
    chk("t1_rvalid", 32'(h_rvalid), 1);
    chk("t1_rdata", 32'(h_rdata), 32'h5A);
    tick();
    chk("t1_rvalid_pulse", 32'(h_rvalid), 0);
    h_req = 1'b0;
    tick();
    chk("t1_rel_gnt", 32'(h_gnt), 0);
    chk("t1_rel_halt", 32'(cpu_halt), 1);
    tick();
    chk("t3_halt_off", 32'(cpu_halt), 0);
    chk("t3_no_run", 32'(cpu_run), 0);
    tick();
    chk("t3_no_run2", 32'(cpu_run), 0);

    // 2: takeover from a running cpu
    cpu_await = 1'b0;
    h_req = 1'b1;
    tick();
    chk("t2_drain_halt", 32'(cpu_halt), 1);
    chk("t2_drain_gnt", 32'(h_gnt), 0);
    cpu_wren = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
    #1;
    chk("t2_cpu_fwd", 32'(ram_wren), 1);
    tick();
    cpu_wren = 1'b0;
    tick();
    chk("t2_drain_gnt2", 32'(h_gnt), 0);
    cpu_await = 1'b1;
    tick();
    chk("t2_gnt", 32'(h_gnt), 1);
    cpu_wren = 1'b1;
    #1;
    chk("t2_cpu_blocked", 32'(ram_wren), 0);
    cpu_wren = 1'b0;
    h_valid = 1'b1; h_we = 1'b0; h_addr = 8'h20;
    tick();
    h_valid = 1'b0;
    tick();
    chk("t2_rvalid", 32'(h_rvalid), 1);
    chk("t2_rdata", 32'(h_rdata), 32'h77);
    h_req = 1'b0;
    tick();
    chk("t2_rel_run", 32'(cpu_run), 0);
    tick();
    chk("t2_run", 32'(cpu_run), 1);
    chk("t2_halt_off", 32'(cpu_halt), 0);
    tick();
    chk("t2_run_pulse", 32'(cpu_run), 0);

    // 4: fill 0..3, back-to-back reads, release on the last one
    h_req = 1'b1;
    tick();
    h_valid = 1'b1; h_we = 1'b1;
    h_addr = 8'h00; h_wdata = 8'hA1; tick();
    h_addr = 8'h01; h_wdata = 8'hB2; tick();
    h_addr = 8'h02; h_wdata = 8'hC3; tick();
    h_addr = 8'h03; h_wdata = 8'hD4; tick();
    h_we = 1'b0;
    h_addr = 8'h00; tick();
    chk("t4_r1_none", 32'(h_rvalid), 0);
    h_addr = 8'h01; tick();
    chk("t4_r2_v", 32'(h_rvalid), 1);
    chk("t4_r2_d", 32'(h_rdata), 32'hA1);
    h_addr = 8'h02; tick();
    chk("t4_r3_v", 32'(h_rvalid), 1);
    chk("t4_r3_d", 32'(h_rdata), 32'hB2);
    h_addr = 8'h03; h_req = 1'b0; tick();
    chk("t4_r4_v", 32'(h_rvalid), 1);
    chk("t4_r4_d", 32'(h_rdata), 32'hC3);
    chk("t4_r4_gnt", 32'(h_gnt), 0);
    chk("t4_r4_halt", 32'(cpu_halt), 1);
    chk("t4_r4_ignored", 32'(ram_rden), 0);
    tick();
    chk("t4_r5_v", 32'(h_rvalid), 1);
    chk("t4_r5_d", 32'(h_rdata), 32'hD4);
    chk("t4_r5_halt", 32'(cpu_halt), 1);
    tick();
    chk("t4_r6_v", 32'(h_rvalid), 0);
    chk("t4_r6_halt", 32'(cpu_halt), 0);
    chk("t4_r6_run", 32'(cpu_run), 0);
    h_valid = 1'b0;
    tick();

    // 5: drain timeout
    cpu_await = 1'b0;
    h_req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t5_derr_d16", 32'(drain_err), 0);
    tick();
    chk("t5_derr_d17", 32'(drain_err), 1);
    chk("t5_gnt", 32'(h_gnt), 0);
    tick();
    chk("t5_gnt2", 32'(h_gnt), 0);
    h_req = 1'b0;
    tick();
    tick();
    chk("t5_halt_off", 32'(cpu_halt), 0);
    chk("t5_run", 32'(cpu_run), 1);
    chk("t5_derr_sticky", 32'(drain_err), 1);
    cpu_await = 1'b1;
    tick();

    // 6: async reset during a host read
    h_req = 1'b1;
    tick();
    h_valid = 1'b1; h_we = 1'b0; h_addr = 8'h02;
    tick();
    h_valid = 1'b0; h_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_gnt", 32'(h_gnt), 0);
    chk("t6_halt", 32'(cpu_halt), 0);
    chk("t6_rvalid", 32'(h_rvalid), 0);
    chk("t6_rdata", 32'(h_rdata), 0);
    chk("t6_derr", 32'(drain_err), 0);
    chk("t6_run", 32'(cpu_run), 0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_rvalid", 32'(h_rvalid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
